atm_ledger_arbiter: RTL and testbench

//  Owns the ATM account-balance ledger and shares it between N requesters (withdraw, deposit, transfer, balance FSMs).

---
 rtl/atm_ledger_arbiter_pkg.sv | 33 +++
 rtl/atm_ledger_arbiter_rr_arbiter.sv | 32 +++
 rtl/atm_ledger_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_atm_ledger_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_ledger_arbiter_pkg.sv
// Shared types for the ATM ledger arbiter: op codes, status codes and FSM states.
// The optional daily debit ceiling is enabled with ATM_LEDGER_DAILY_LIMIT_EN.
package atm_ledger_arbiter_pkg;

  localparam int BAL_W = 32;

  typedef enum logic [1:0] {
    OP_BAL  = 2'd0,
    OP_DEP  = 2'd1,
    OP_WDR  = 2'd2,
    OP_XFER = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_NSF      = 3'd1,
    ST_BAD_ACCT = 3'd2,
    ST_OVERFLOW = 3'd3,
    ST_LIMIT    = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  function automatic logic is_debit(op_e op);
    return (op == OP_WDR) || (op == OP_XFER);
  endfunction

endpackage

// File: rtl/atm_ledger_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
// Purely combinational so other blocks can reuse it with their own pointer register.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Ledger owner: round-robin grant, then EXEC/COMMIT/RESP so every debit/credit is atomic.
// Define ATM_LEDGER_DAILY_LIMIT_EN to add per-account daily debit totals and the LIMIT status.
module atm_ledger_arbiter
  import atm_ledger_arbiter_pkg::*;
#(
  parameter int          NUM_REQ      = 4,
  parameter int          NUM_ACCTS    = 8,
  parameter logic [31:0] INIT_BALANCE = 32'h186A0,
  parameter logic [31:0] DAILY_LIMIT  = 32'd20000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [2*NUM_REQ-1:0]             req_op,
  input  logic [$clog2(NUM_ACCTS)*NUM_REQ-1:0] req_src,
  input  logic [$clog2(NUM_ACCTS)*NUM_REQ-1:0] req_dst,
  input  logic [32*NUM_REQ-1:0]            req_amt,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [2:0]                       rsp_status,
  output logic [31:0]                      rsp_balance,
  input  logic                             day_clr,
  output logic                             busy
);

  localparam int AW = $clog2(NUM_ACCTS);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [AW:0] ACCT_LIM = (AW+1)'(NUM_ACCTS);

  state_e state_q, state_d;

  logic [IW-1:0]      rr_q;
  logic [NUM_REQ-1:0] arb_grant, grant_q;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  logic [1:0]         sel_op;
  logic [AW-1:0]      sel_src, sel_dst;
  logic [31:0]        sel_amt;

  op_e                op_q;
  logic [AW-1:0]      src_q, dst_q;
  logic [31:0]        amt_q;
  status_e            status_q, exec_status;
  logic [31:0]        new_src_q, new_dst_q, exec_new_src, exec_new_dst;

  logic [31:0]        ledger [NUM_ACCTS];

  logic               src_ok, dst_ok, debit, limit_hit;
  logic [31:0]        bal_src, bal_dst;
  logic [32:0]        sum_src, sum_dst;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    sel_op  = '0;
    sel_src = '0;
    sel_dst = '0;
    sel_amt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_op  = req_op[i*2 +: 2];
        sel_src = req_src[i*AW +: AW];
        sel_dst = req_dst[i*AW +: AW];
        sel_amt = req_amt[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          state_d   = S_EXEC;
        end
      end
      S_EXEC:   state_d = S_COMMIT;
      S_COMMIT: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = grant_q;
        state_d   = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign rsp_status  = status_q;
  assign rsp_balance = new_src_q;
  assign debit       = is_debit(op_q);

  always_comb begin
    src_ok       = ({1'b0, src_q} < ACCT_LIM);
    dst_ok       = ({1'b0, dst_q} < ACCT_LIM);
    bal_src      = src_ok ? ledger[src_q] : '0;
    bal_dst      = dst_ok ? ledger[dst_q] : '0;
    sum_src      = {1'b0, bal_src} + {1'b0, amt_q};
    sum_dst      = {1'b0, bal_dst} + {1'b0, amt_q};
    exec_status  = ST_OK;
    exec_new_src = bal_src;
    exec_new_dst = bal_dst;
    // Priority: account check, daily limit, funds, then credit carry-out.
    if (!src_ok || (op_q == OP_XFER && (!dst_ok || src_q == dst_q)))
      exec_status = ST_BAD_ACCT;
    else if (limit_hit)
      exec_status = ST_LIMIT;
    else if (debit && amt_q > bal_src)
      exec_status = ST_NSF;
    else if (op_q == OP_DEP && sum_src[32])
      exec_status = ST_OVERFLOW;
    else if (op_q == OP_XFER && sum_dst[32])
      exec_status = ST_OVERFLOW;
    else begin
      case (op_q)
        OP_DEP:  exec_new_src = sum_src[31:0];
        OP_WDR:  exec_new_src = bal_src - amt_q;
        OP_XFER: begin
          exec_new_src = bal_src - amt_q;
          exec_new_dst = sum_dst[31:0];
        end
        default: exec_new_src = bal_src;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      op_q      <= OP_BAL;
      src_q     <= '0;
      dst_q     <= '0;
      amt_q     <= '0;
      status_q  <= ST_OK;
      new_src_q <= '0;
      new_dst_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && arb_any) begin
        grant_q <= arb_grant;
        rr_q    <= (arb_idx == IW'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
        op_q    <= op_e'(sel_op);
        src_q   <= sel_src;
        dst_q   <= sel_dst;
        amt_q   <= sel_amt;
      end
      if (state_q == S_EXEC) begin
        status_q  <= exec_status;
        new_src_q <= exec_new_src;
        new_dst_q <= exec_new_dst;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACCTS; i++) ledger[i] <= INIT_BALANCE;
    end else if (state_q == S_COMMIT && status_q == ST_OK) begin
      ledger[src_q] <= new_src_q;
      if (op_q == OP_XFER) ledger[dst_q] <= new_dst_q;
    end
  end

`ifdef ATM_LEDGER_DAILY_LIMIT_EN
  logic [31:0] debit_total [NUM_ACCTS];
  logic [32:0] debit_sum;

  assign debit_sum = {1'b0, (src_ok ? debit_total[src_q] : 32'd0)} + {1'b0, amt_q};
  assign limit_hit = debit && (debit_sum > {1'b0, DAILY_LIMIT});

  // day_clr wins over a same-cycle commit so a new day always starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACCTS; i++) debit_total[i] <= '0;
    end else if (day_clr) begin
      for (int i = 0; i < NUM_ACCTS; i++) debit_total[i] <= '0;
    end else if (state_q == S_COMMIT && status_q == ST_OK && debit) begin
      debit_total[src_q] <= debit_total[src_q] + amt_q;
    end
  end
`else
  logic unused_limit;
  assign limit_hit    = 1'b0;
  assign unused_limit = day_clr ^ (^DAILY_LIMIT) ^ (^new_dst_q[0]) ^ 1'b0;
`endif

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Self-checking bench for atm_ledger_arbiter: directed cases plus random ops against a ledger model.
module tb_atm_ledger_arbiter;

  localparam int NR = 4;
  localparam int NA = 8;
  localparam int AW = 3;
  localparam longint INIT = 100000;
  localparam longint MAXU = 64'hFFFF_FFFF;
  localparam longint DLIM = 20000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [2*NR-1:0]   req_op = '0;
  logic [AW*NR-1:0]  req_src = '0;
  logic [AW*NR-1:0]  req_dst = '0;
  logic [32*NR-1:0]  req_amt = '0;
  logic [NR-1:0]     rsp_valid;
  logic [2:0]        rsp_status;
  logic [31:0]       rsp_balance;
  logic              day_clr = 1'b0;
  logic              busy;

  int vecs = 0;
  int errs = 0;

  longint m_bal [NA];
  longint m_deb [NA];

  always #5 clk = ~clk;

  atm_ledger_arbiter #(
    .NUM_REQ(NR), .NUM_ACCTS(NA), .INIT_BALANCE(32'h186A0), .DAILY_LIMIT(32'd20000)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src(req_src), .req_dst(req_dst), .req_amt(req_amt),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_balance(rsp_balance),
    .day_clr(day_clr), .busy(busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NA; i++) begin
      m_bal[i] = INIT;
      m_deb[i] = 0;
    end
  endfunction

  // Ledger rules as plain arithmetic; applies the op to the model and returns the expected response.
  function automatic void model_op(input int op, input int src, input int dst, input longint amt,
                                   output int st, output longint bal);
    bit is_deb;
    is_deb = (op == 2) || (op == 3);
    st = -1;
    if (src >= NA || (op == 3 && (dst >= NA || src == dst))) st = 2;
`ifdef ATM_LEDGER_DAILY_LIMIT_EN
    if (st < 0 && is_deb && m_deb[src] + amt > DLIM) st = 4;
`endif
    if (st < 0 && is_deb && amt > m_bal[src]) st = 1;
    if (st < 0 && op == 1 && m_bal[src] + amt > MAXU) st = 3;
    if (st < 0 && op == 3 && m_bal[dst] + amt > MAXU) st = 3;
    if (st < 0) begin
      st = 0;
      if (op == 1) m_bal[src] += amt;
      if (is_deb) begin
        m_bal[src] -= amt;
        m_deb[src] += amt;
      end
      if (op == 3) m_bal[dst] += amt;
    end
    bal = (src < NA) ? m_bal[src] : 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    day_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_status", rsp_status, 0);
    check("rst_balance", rsp_balance, 0);
  endtask

  task automatic pulse_day_clr();
    @(negedge clk);
    day_clr = 1'b1;
    @(negedge clk);
    day_clr = 1'b0;
    for (int i = 0; i < NA; i++) m_deb[i] = 0;
  endtask

  task automatic do_req(input int r, input int op, input int src, input int dst,
                        input logic [31:0] amt, output logic [2:0] o_st, output logic [31:0] o_bal);
    int st_e;
    longint bal_e;
    int lat;
    logic [1:0] op2;
    op2 = op[1:0];
    @(negedge clk);
    req_op[r*2 +: 2]   = op2;
    req_src[r*AW +: AW] = AW'(src);
    req_dst[r*AW +: AW] = AW'(dst);
    req_amt[r*32 +: 32] = amt;
    req_valid[r] = 1'b1;
    #1;
    check("req_ready", req_ready, 64'(1) << r);
    model_op(op, src, dst, longint'(amt), st_e, bal_e);
    @(posedge clk);
    @(negedge clk);
    req_valid[r] = 1'b0;
    check("busy_exec", busy, 1);
    lat = 1;
    while (rsp_valid === '0 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    check("rsp_onehot", rsp_valid, 64'(1) << r);
    check("rsp_status", rsp_status, st_e);
    check("rsp_balance", rsp_balance, bal_e);
    o_st  = rsp_status;
    o_bal = rsp_balance;
    @(negedge clk);
    check("rsp_drop", rsp_valid, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    logic [2:0]  st;
    logic [31:0] bal;
    logic [NR-1:0] drop;
    int n_grant, n_rsp, last_c;

    do_reset();

    // Directed: withdraw, NSF boundary, exact-balance withdraw
    do_req(2, 2, 0, 0, 32'd5000, st, bal);
    check("t1_status", st, 0);
    check("t1_balance", bal, 95000);
    do_req(1, 2, 1, 0, 32'd100001, st, bal);
    check("t2_nsf", st, 1);
    check("t2_nsf_bal", bal, 100000);
    do_req(0, 2, 1, 0, 32'd100000, st, bal);
    check("t2_exact", st, 0);
    check("t2_exact_bal", bal, 0);

    // Transfers and same-account transfer
    do_req(3, 3, 2, 3, 32'd30000, st, bal);
    check("t3_xfer_bal", bal, 70000);
    do_req(1, 0, 3, 0, 32'd0, st, bal);
    check("t3_bal3", bal, 130000);
    do_req(2, 3, 4, 4, 32'd10, st, bal);
    check("t3_same_acct", st, 2);

    // Deposit overflow
    do_req(0, 1, 5, 0, 32'hFFFF_FFFF, st, bal);
    check("t5_ovf", st, 3);
    check("t5_ovf_bal", bal, 100000);

    // Random ops against the model
    for (int k = 0; k < 40; k++) begin
      int r, op, src, dst, sel;
      logic [31:0] amt;
      r   = int'($urandom_range(0, NR-1));
      op  = int'($urandom_range(0, 3));
      src = int'($urandom_range(0, NA-1));
      dst = ($urandom_range(0, 5) == 0) ? src : int'($urandom_range(0, NA-1));
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: amt = $urandom_range(0, 20000);
        1: amt = 32'(m_bal[src]);
        2: amt = 32'(m_bal[src] + 1);
        3: amt = 32'(MAXU - m_bal[dst]);
        4: amt = $urandom;
        default: amt = $urandom_range(0, 3000);
      endcase
      if ($urandom_range(0, 9) == 0) pulse_day_clr();
      do_req(r, op, src, dst, amt, st, bal);
    end

    // Reset while the transaction sits in COMMIT
    @(negedge clk);
    req_op[1:0] = 2'd2;
    req_src[AW-1:0] = AW'(5);
    req_amt[31:0] = 32'd1000;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_no_rsp", rsp_valid, 0);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_no_rsp", rsp_valid, 0);
    end
    do_req(0, 0, 5, 0, 32'd0, st, bal);
    check("mid_acct5", bal, 100000);
    do_req(2, 0, 0, 0, 32'd0, st, bal);
    check("mid_acct0", bal, 100000);

    // All requesters held from the first idle cycle after reset
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      req_op[i*2 +: 2] = 2'd0;
      req_src[i*AW +: AW] = AW'(i);
      req_amt[i*32 +: 32] = 32'd0;
    end
    req_valid = '1;
    n_grant = 0;
    n_rsp = 0;
    last_c = 0;
    for (int c = 0; c < 40 && n_rsp < NR; c++) begin
      #1;
      drop = '0;
      if (req_ready !== '0) begin
        check("rr_grant", req_ready, 64'(1) << n_grant);
        if (n_grant > 0) check("rr_spacing", c - last_c, 4);
        last_c = c;
        drop = req_ready;
        n_grant++;
      end
      if (rsp_valid !== '0) begin
        check("rr_rsp_onehot", rsp_valid, 64'(1) << n_rsp);
        check("rr_rsp_bal", rsp_balance, m_bal[n_rsp]);
        n_rsp++;
      end
      @(negedge clk);
      req_valid = req_valid & ~drop;
    end
    check("rr_grants", n_grant, NR);
    check("rr_rsps", n_rsp, NR);

`ifdef ATM_LEDGER_DAILY_LIMIT_EN
    do_req(1, 2, 6, 0, 32'd15000, st, bal);
    check("t6_first", st, 0);
    do_req(1, 2, 6, 0, 32'd6000, st, bal);
    check("t6_limit", st, 4);
    check("t6_limit_bal", bal, 85000);
    pulse_day_clr();
    do_req(1, 2, 6, 0, 32'd6000, st, bal);
    check("t6_retry", st, 0);
    check("t6_retry_bal", bal, 79000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
